simple_spi_master: RTL and testbench

SPI mode-0 master: the initiating end of the link served by `simple_spi_slave`. On a single-cycle `start` strobe it asserts `pin_ncs`, generates `WIDTH` clock pulses on `pin_clk` at a rate set by `CLKDIV`, and shifts `value_mosi` out MSB-first. It simultaneously shifts `pin_miso` in and presents the received word with a one-cycle `done` pulse. All logic runs in the `system_clk` domain; `pin_miso` is the only asynchronous input.

---
 rtl/simple_spi_master.sv | 127 ++++++++++++
 tb/tb_simple_spi_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_spi_master.sv
// SPI mode-0 master: frames a WIDTH-bit MSB-first exchange with chip select,
// SCK at system_clk/(2*CLKDIV), and a CLKDIV-long setup, hold and gap.
module simple_spi_master #(
    parameter int WIDTH  = 4,
    parameter int CLKDIV = 8
) (
    input  logic             system_clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [WIDTH-1:0] value_mosi,
    output logic [WIDTH-1:0] value_miso,
    output logic             busy,
    output logic             done,
    output logic             pin_ncs,
    output logic             pin_clk,
    output logic             pin_mosi,
    input  logic             pin_miso
);
    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] tx_q, rx_q, value_miso_q;
    logic             busy_q, done_q, ncs_q, clk_q, mosi_q;
    logic             meta_q, sync_q;
    logic             tick;

    // Every state lasts CLKDIV cycles, so the counter simply reloads on expiry.
    assign tick  = (cnt_q == '0);
    assign cnt_d = tick ? DIV_LAST : cnt_q - CW'(1);

    always_ff @(posedge system_clk or negedge nreset) begin
        if (!nreset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= pin_miso;
            sync_q <= meta_q;
        end
    end

    always_ff @(posedge system_clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            value_miso_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ncs_q        <= 1'b1;
            clk_q        <= 1'b0;
            mosi_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tx_q    <= value_mosi;
                        bit_q   <= '0;
                        cnt_q   <= DIV_LAST;
                        busy_q  <= 1'b1;
                        ncs_q   <= 1'b0;
                        mosi_q  <= value_mosi[WIDTH-1];
                        state_q <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    cnt_q <= cnt_d;
                    if (tick) begin
                        clk_q   <= 1'b1;
                        rx_q    <= {rx_q[WIDTH-2:0], sync_q};
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    cnt_q <= cnt_d;
                    if (tick) begin
                        clk_q <= 1'b0;
                        // The falling edge after the last bit doubles as the start of HOLD.
                        if (bit_q == BIT_LAST) begin
                            mosi_q  <= 1'b0;
                            state_q <= HOLD;
                        end else begin
                            tx_q    <= {tx_q[WIDTH-2:0], 1'b0};
                            mosi_q  <= tx_q[WIDTH-2];
                            bit_q   <= bit_q + BW'(1);
                            state_q <= LOW;
                        end
                    end
                end
                HOLD: begin
                    cnt_q <= cnt_d;
                    if (tick) begin
                        ncs_q        <= 1'b1;
                        done_q       <= 1'b1;
                        value_miso_q <= rx_q;
                        state_q      <= GAP;
                    end
                end
                GAP: begin
                    cnt_q <= cnt_d;
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign value_miso = value_miso_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pin_ncs    = ncs_q;
    assign pin_clk    = clk_q;
    assign pin_mosi   = mosi_q;

endmodule

// File: tb/tb_simple_spi_master.sv
// Bench for simple_spi_master: a WIDTH=4/CLKDIV=8 instance with a mode-0 slave
// model, plus a CLKDIV=2 instance driven by a fast behavioural slave.
module tb_simple_spi_master;
    logic       system_clk = 1'b0;
    logic       nreset     = 1'b0;
    logic       start      = 1'b0;
    logic [3:0] value_mosi = '0;
    logic [3:0] value_miso;
    logic       busy, done, pin_ncs, pin_clk, pin_mosi;
    logic       miso_a     = 1'b0;

    logic       start2 = 1'b0;
    logic [3:0] vm2    = '0;
    logic [3:0] value_miso2;
    logic       busy2, done2, ncs2, clk2, mosi2;
    logic       miso2  = 1'b0;

    simple_spi_master #(.WIDTH(4), .CLKDIV(8)) dut (
        .system_clk(system_clk), .nreset(nreset), .start(start),
        .value_mosi(value_mosi), .value_miso(value_miso), .busy(busy),
        .done(done), .pin_ncs(pin_ncs), .pin_clk(pin_clk),
        .pin_mosi(pin_mosi), .pin_miso(miso_a)
    );

    simple_spi_master #(.WIDTH(4), .CLKDIV(2)) dut_fast (
        .system_clk(system_clk), .nreset(nreset), .start(start2),
        .value_mosi(vm2), .value_miso(value_miso2), .busy(busy2),
        .done(done2), .pin_ncs(ncs2), .pin_clk(clk2),
        .pin_mosi(mosi2), .pin_miso(miso2)
    );

    always #5 system_clk = ~system_clk;

    int cyc = 0;
    always @(posedge system_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mode-0 slave model and link monitor for the CLKDIV=8 instance.
    logic [3:0] slv_tx = '0;
    logic [3:0] s_sh   = '0;
    logic [3:0] s_rx   = '0;
    logic       prev_ncs = 1'b1, prev_clk = 1'b0, prev_mosi = 1'b0;
    int         t0 = 0, rises = 0, glitch = 0, done_cnt = 0, done_rel = -1, ncs_run = 0;
    logic [3:0] got_s[$];
    logic [3:0] got_m[$];
    int         gaps[$];

    always @(negedge system_clk) begin
        if (!nreset) begin
            prev_ncs  = 1'b1;
            prev_clk  = 1'b0;
            prev_mosi = 1'b0;
        end else begin
            if (prev_ncs && !pin_ncs) begin
                s_sh   = slv_tx;
                miso_a = s_sh[3];
                s_rx   = '0;
                gaps.push_back(ncs_run);
                ncs_run = 0;
            end
            if (pin_ncs) ncs_run++;
            if (!prev_clk && pin_clk) begin
                s_rx = {s_rx[2:0], pin_mosi};
                rises++;
            end
            if (prev_clk && !pin_clk) begin
                s_sh   = {s_sh[2:0], 1'b0};
                miso_a = s_sh[3];
            end
            if (prev_clk && pin_clk && (pin_mosi != prev_mosi)) glitch++;
            if (!prev_ncs && pin_ncs) got_s.push_back(s_rx);
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0 + 1;
                got_m.push_back(value_miso);
            end
            prev_ncs  = pin_ncs;
            prev_clk  = pin_clk;
            prev_mosi = pin_mosi;
        end
    end

    task automatic begin_xfer(input logic [3:0] m, input logic [3:0] s);
        @(negedge system_clk);
        got_s.delete();
        got_m.delete();
        rises    = 0;
        glitch   = 0;
        done_cnt = 0;
        done_rel = -1;
        slv_tx     = s;
        value_mosi = m;
        start      = 1'b1;
        @(posedge system_clk);
        #1 t0 = cyc;
    endtask

    task automatic wait_xfer(input string tag, input logic [3:0] m, input logic [3:0] s,
                             input bit ign);
        int rel;
        int busy_rel;
        busy_rel = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge system_clk);
            rel   = cyc - t0 + 1;
            start = ign && (rel == 20);
            if (ign && rel == 20) value_mosi = 4'b1111;
            if (!busy) begin
                busy_rel = rel;
                break;
            end
        end
        chk({tag, " busy_fall"}, busy_rel, 81);
        chk({tag, " done_cycle"}, done_rel, 73);
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " sck_rises"}, rises, 4);
        chk({tag, " mosi_glitch"}, glitch, 0);
        chk({tag, " slave_rx"}, (got_s.size() > 0) ? got_s[0] : 4'bx, m);
        chk({tag, " master_rx"}, (got_m.size() > 0) ? got_m[0] : 4'bx, s);
    endtask

    typedef struct {
        logic [3:0] m;
        logic [3:0] s;
        logic [3:0] exp_slave;
        logic [3:0] exp_master;
    } vec_t;
    vec_t vecs[12];

    logic [3:0] s2, srx2, got2;
    logic       p2;
    int         bi, d2rel, t0b, stage, done_before;

    initial begin
        vecs[0]  = '{4'b1010, 4'b0110, 4'b1010, 4'b0110};
        vecs[1]  = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
        vecs[2]  = '{4'b0101, 4'b1010, 4'b0101, 4'b1010};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
        vecs[4]  = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
        vecs[5]  = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
        vecs[6]  = '{4'b0100, 4'b0010, 4'b0100, 4'b0010};
        vecs[7]  = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
        vecs[8]  = '{4'b1110, 4'b0111, 4'b1110, 4'b0111};
        vecs[9]  = '{4'b1101, 4'b1011, 4'b1101, 4'b1011};
        vecs[10] = '{4'b1011, 4'b1101, 4'b1011, 4'b1101};
        vecs[11] = '{4'b0111, 4'b1110, 4'b0111, 4'b1110};

        repeat (2) @(negedge system_clk);
        chk("rst pin_ncs", pin_ncs, 1);
        chk("rst pin_clk", pin_clk, 0);
        chk("rst pin_mosi", pin_mosi, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst value_miso", value_miso, 0);
        nreset = 1'b1;

        // Single transfer, then every pattern pair.
        begin_xfer(4'b0110, 4'b1010);
        wait_xfer("single", 4'b0110, 4'b1010, 1'b0);
        for (int i = 0; i < 12; i++) begin
            begin_xfer(vecs[i].m, vecs[i].s);
            wait_xfer($sformatf("vec%0d", i), vecs[i].exp_slave, vecs[i].exp_master, 1'b0);
        end

        // A start pulse mid-transfer must be dropped.
        begin_xfer(4'b0001, 4'b0101);
        wait_xfer("ignored_start", 4'b0001, 4'b0101, 1'b1);
        repeat (20) @(negedge system_clk);
        chk("ignored_start not_queued", busy, 0);

        // Back-to-back with start held high.
        @(negedge system_clk);
        got_s.delete();
        got_m.delete();
        gaps.delete();
        done_cnt   = 0;
        stage      = 0;
        value_mosi = 4'b1000;
        slv_tx     = 4'b0011;
        start      = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge system_clk);
            if (done_cnt == 1 && stage == 0) begin
                value_mosi = 4'b0100; slv_tx = 4'b1100; stage = 1;
            end else if (done_cnt == 2 && stage == 1) begin
                value_mosi = 4'b0010; slv_tx = 4'b1001; stage = 2;
            end else if (done_cnt == 3) begin
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        for (int k = 0; k < 100 && busy; k++) @(negedge system_clk);
        chk("b2b done_count", done_cnt, 3);
        chk("b2b slave0", (got_s.size() > 0) ? got_s[0] : 4'bx, 4'b1000);
        chk("b2b slave1", (got_s.size() > 1) ? got_s[1] : 4'bx, 4'b0100);
        chk("b2b slave2", (got_s.size() > 2) ? got_s[2] : 4'bx, 4'b0010);
        chk("b2b master2", (got_m.size() > 2) ? got_m[2] : 4'bx, 4'b1001);
        chk("b2b gap1", (gaps.size() > 1) ? gaps[1] : -1, 9);
        chk("b2b gap2", (gaps.size() > 2) ? gaps[2] : -1, 9);

        // Reset after the second SCK rise aborts the transfer with no done.
        begin_xfer(4'b0111, 4'b0011);
        @(negedge system_clk);
        start = 1'b0;
        for (int k = 0; k < 100 && rises < 2; k++) @(negedge system_clk);
        done_before = done_cnt;
        #2 nreset = 1'b0;
        #1;
        chk("midrst pin_ncs", pin_ncs, 1);
        chk("midrst pin_clk", pin_clk, 0);
        chk("midrst busy", busy, 0);
        chk("midrst value_miso", value_miso, 0);
        repeat (3) @(negedge system_clk);
        nreset = 1'b1;
        repeat (100) @(negedge system_clk);
        chk("midrst no_done", done_cnt, done_before);
        chk("midrst no_word", got_m.size(), 0);
        begin_xfer(4'b1101, 4'b1001);
        wait_xfer("after_rst", 4'b1101, 4'b1001, 1'b0);

        // CLKDIV=2: the slave presents each next bit right after the rise.
        s2    = 4'b0110;
        srx2  = '0;
        got2  = 'x;
        p2    = 1'b0;
        bi    = 0;
        d2rel = -1;
        @(negedge system_clk);
        vm2    = 4'b1001;
        miso2  = s2[3];
        start2 = 1'b1;
        @(posedge system_clk);
        #1 t0b = cyc;
        for (int k = 0; k < 80; k++) begin
            @(negedge system_clk);
            start2 = 1'b0;
            if (!p2 && clk2) begin
                srx2 = {srx2[2:0], mosi2};
                bi++;
                if (bi < 4) miso2 = s2[3-bi];
            end
            p2 = clk2;
            if (done2) begin
                d2rel = cyc - t0b + 1;
                got2  = value_miso2;
            end
            if (!busy2) break;
        end
        chk("fast master_rx", got2, 4'b0110);
        chk("fast slave_rx", srx2, 4'b1001);
        chk("fast done_cycle", d2rel, 19);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
